// File: rtl/alu_pkg.sv
// Shared encodings for the ALU instruction sequencer: opcodes, writeback
// source selects, FSM state codes and the opcode class bundle.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SHL  = 4'd2;
  localparam logic [3:0] OP_SHR  = 4'd3;
  localparam logic [3:0] OP_CMP  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_NAND = 4'd8;
  localparam logic [3:0] OP_NOR  = 4'd9;
  localparam logic [3:0] OP_XNOR = 4'd10;
  localparam logic [3:0] OP_INV  = 4'd11;
  localparam logic [3:0] OP_NEG  = 4'd12;
  localparam logic [3:0] OP_STO  = 4'd13;
  localparam logic [3:0] OP_SWP  = 4'd14;
  localparam logic [3:0] OP_LOAD = 4'd15;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_A   = 2'd1;
  localparam logic [1:0] WB_B   = 2'd2;
  localparam logic [1:0] WB_MEM = 2'd3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_WB2    = 3'd4;
  localparam logic [2:0] S_MEM    = 3'd5;

  // Per-opcode behaviour classes used by the sequencer
  typedef struct packed {
    logic writes_rf;
    logic sets_flags;
    logic is_mem;
    logic is_swp;
  } op_class_t;

endpackage

// File: rtl/alu_ctrl_seq_op_decoder.sv
// Combinational opcode decoder: one-hot ALU select plus class bits that
// steer the sequencer (RF write, flag update, memory op, swap).
module op_decoder
  import alu_pkg::*;
(
  input  logic [3:0]  opcode,
  output logic [15:0] op_sel,
  output op_class_t   cls
);

  // One-hot select and class lookup
  always_comb begin
    op_sel         = 16'd1 << opcode;
    cls.writes_rf  = !((opcode == OP_CMP) || (opcode == OP_STO));
    cls.sets_flags = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_SHL) || (opcode == OP_SHR) ||
                     (opcode == OP_CMP) || (opcode == OP_NEG);
    cls.is_mem     = (opcode == OP_STO) || (opcode == OP_LOAD);
    cls.is_swp     = (opcode == OP_SWP);
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Instruction sequencer in front of the ALU op units. Takes one 8-bit
// instruction at a time over valid/ready, walks it through
// DECODE/EXEC/WB(/WB2)/MEM and drives RF, flag and memory controls.
// All outputs are Moore: decoded from state and the captured instruction.
module alu_ctrl_seq
  import alu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int RA_W        = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic [15:0]     op_sel,
  output logic [RA_W-1:0] ra_addr,
  output logic [RA_W-1:0] rb_addr,
  output logic            opl_en,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_waddr,
  output logic [1:0]      wb_sel,
  output logic            flag_we,
  output logic            mem_req,
  output logic            mem_we,
  input  logic            mem_ack,
  output logic            busy,
  output logic            err
);

  logic [2:0]      state, state_nx;
  logic [7:0]      ir;
  logic [7:0]      wait_cnt;
  logic            err_q;
  logic [15:0]     dec_sel;
  op_class_t       cls;
  logic [3:0]      opcode;
  logic [RA_W-1:0] rd, rs;
  logic            mem_timeout;

  assign opcode      = ir[7:4];
  assign rd          = RA_W'(ir[3:2]);
  assign rs          = RA_W'(ir[1:0]);
  assign mem_timeout = (wait_cnt == 8'(MEM_TIMEOUT - 1));

  op_decoder u_dec (
    .opcode (opcode),
    .op_sel (dec_sel),
    .cls    (cls)
  );

  // Next-state selection
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (instr_valid) state_nx = S_DECODE;
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        if (cls.is_mem)          state_nx = S_MEM;
        else if (!cls.writes_rf) state_nx = S_IDLE;
        else                     state_nx = S_WB;
      end
      S_WB:     state_nx = cls.is_swp ? S_WB2 : S_IDLE;
      S_WB2:    state_nx = S_IDLE;
      S_MEM: begin
        // an ack in the final wait cycle still wins over the timeout
        if (mem_ack)          state_nx = cls.writes_rf ? S_WB : S_IDLE;
        else if (mem_timeout) state_nx = S_IDLE;
      end
      default:  state_nx = S_IDLE;
    endcase
  end

  // State, instruction capture, memory wait counter and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ir       <= 8'd0;
      wait_cnt <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nx;
      if ((state == S_IDLE) && instr_valid) ir <= instr;
      // counter sits at 0 outside MEM so it starts from 0 on every entry
      if (state == S_MEM) wait_cnt <= wait_cnt + 8'd1;
      else                wait_cnt <= 8'd0;
      if ((state == S_MEM) && !mem_ack && mem_timeout) err_q <= 1'b1;
    end
  end

  // Moore output decode from state and captured instruction
  always_comb begin
    instr_ready = (state == S_IDLE);
    busy        = (state != S_IDLE);
    ra_addr     = rd;
    rb_addr     = rs;
    opl_en      = (state == S_DECODE);
    op_sel      = 16'd0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    wb_sel      = WB_ALU;
    flag_we     = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    err         = err_q;
    case (state)
      S_EXEC: begin
        op_sel  = dec_sel;
        flag_we = cls.sets_flags;
      end
      S_WB: begin
        op_sel   = dec_sel;
        rf_we    = 1'b1;
        rf_waddr = rd;
        if (cls.is_swp)      wb_sel = WB_B;
        else if (cls.is_mem) wb_sel = WB_MEM;
        else                 wb_sel = WB_ALU;
      end
      S_WB2: begin
        op_sel   = dec_sel;
        rf_we    = 1'b1;
        rf_waddr = rs;
        wb_sel   = WB_A;
      end
      S_MEM: begin
        op_sel  = dec_sel;
        mem_req = 1'b1;
        mem_we  = (opcode == OP_STO);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: stimulus pushes expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_alu_ctrl_seq;

  logic        clk;
  logic        rst_n;
  logic [7:0]  instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] op_sel;
  logic [1:0]  ra_addr, rb_addr, rf_waddr, wb_sel;
  logic        opl_en, rf_we, flag_we, mem_req, mem_we, mem_ack, busy, err;

  alu_ctrl_seq #(.MEM_TIMEOUT(15), .RA_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .op_sel      (op_sel),
    .ra_addr     (ra_addr),
    .rb_addr     (rb_addr),
    .opl_en      (opl_en),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .wb_sel      (wb_sel),
    .flag_we     (flag_we),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_ack     (mem_ack),
    .busy        (busy),
    .err         (err)
  );

  typedef struct { int c; logic [1:0] a; logic [1:0] s; logic [15:0] op; } wexp_t;
  typedef struct { int c; logic [15:0] op; } fexp_t;
  typedef struct { int c; int len; logic we; logic [15:0] op; } mexp_t;
  typedef struct { int c; logic [1:0] ra; logic [1:0] rb; } dexp_t;

  wexp_t wq[$];
  fexp_t fq[$];
  mexp_t mq[$];
  dexp_t dq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int h;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycle index: value seen between two rising edges
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor ----------------
  wexp_t we_e;
  fexp_t fe_e;
  mexp_t me_e;
  dexp_t de_e;
  logic  mreq_prev = 1'b0;
  int    mstart = 0;
  logic  mwe = 1'b0;
  logic [15:0] mop = 16'd0;

  always @(negedge clk) begin
    if (rf_we) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL rf_write_unexpected: got cyc=%0d waddr=%0d wb_sel=%0d, expected no write",
                 cyc, rf_waddr, wb_sel);
      end else begin
        we_e = wq.pop_front();
        if (cyc != we_e.c || rf_waddr != we_e.a || wb_sel != we_e.s || op_sel != we_e.op) begin
          errors++;
          $display("FAIL rf_write: got cyc=%0d waddr=%0d wb_sel=%0d op_sel=%h, expected cyc=%0d waddr=%0d wb_sel=%0d op_sel=%h",
                   cyc, rf_waddr, wb_sel, op_sel, we_e.c, we_e.a, we_e.s, we_e.op);
        end
      end
    end
    if (flag_we) begin
      checks++;
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL flag_we_unexpected: got cyc=%0d op_sel=%h, expected no flag update", cyc, op_sel);
      end else begin
        fe_e = fq.pop_front();
        if (cyc != fe_e.c || op_sel != fe_e.op || rf_we) begin
          errors++;
          $display("FAIL flag_we: got cyc=%0d op_sel=%h rf_we=%0b, expected cyc=%0d op_sel=%h rf_we=0",
                   cyc, op_sel, rf_we, fe_e.c, fe_e.op);
        end
      end
    end
    if (opl_en) begin
      checks++;
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL opl_en_unexpected: got cyc=%0d, expected no operand latch", cyc);
      end else begin
        de_e = dq.pop_front();
        if (cyc != de_e.c || ra_addr != de_e.ra || rb_addr != de_e.rb) begin
          errors++;
          $display("FAIL decode: got cyc=%0d ra=%0d rb=%0d, expected cyc=%0d ra=%0d rb=%0d",
                   cyc, ra_addr, rb_addr, de_e.c, de_e.ra, de_e.rb);
        end
      end
    end
    if (mem_req && !mreq_prev) begin
      mstart = cyc;
      mwe    = mem_we;
      mop    = op_sel;
    end
    if (!mem_req && mreq_prev) begin
      checks++;
      if (mq.size() == 0) begin
        errors++;
        $display("FAIL mem_req_unexpected: got start=%0d len=%0d, expected no request", mstart, cyc - mstart);
      end else begin
        me_e = mq.pop_front();
        if (mstart != me_e.c || (cyc - mstart) != me_e.len || mwe != me_e.we || mop != me_e.op) begin
          errors++;
          $display("FAIL mem_req: got start=%0d len=%0d we=%0b op_sel=%h, expected start=%0d len=%0d we=%0b op_sel=%h",
                   mstart, cyc - mstart, mwe, mop, me_e.c, me_e.len, me_e.we, me_e.op);
        end
      end
    end
    mreq_prev = mem_req;
  end

  // ---------------- expectation helpers ----------------
  task automatic expw(input int c, input logic [1:0] a, input logic [1:0] s, input logic [15:0] op);
    wexp_t e;
    e.c = c; e.a = a; e.s = s; e.op = op;
    wq.push_back(e);
  endtask

  task automatic expf(input int c, input logic [15:0] op);
    fexp_t e;
    e.c = c; e.op = op;
    fq.push_back(e);
  endtask

  task automatic expm(input int c, input int len, input logic we, input logic [15:0] op);
    mexp_t e;
    e.c = c; e.len = len; e.we = we; e.op = op;
    mq.push_back(e);
  endtask

  task automatic expd(input int c, input logic [1:0] ra, input logic [1:0] rb);
    dexp_t e;
    e.c = c; e.ra = ra; e.rb = rb;
    dq.push_back(e);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [7:0] ins, output int hc);
    int t;
    t = 0;
    @(negedge clk);
    while (!instr_ready && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!instr_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_ready: got instr_ready=0 after %0d cycles, expected 1", t);
    end
    instr       = ins;
    instr_valid = 1'b1;
    hc          = cyc;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = ~ins;
  endtask

  task automatic wait_ready(input int exp_c, input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (!instr_ready && t < 60) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!instr_ready || cyc != exp_c || busy) begin
      errors++;
      $display("FAIL %s: got ready=%0b cyc=%0d busy=%0b, expected ready=1 cyc=%0d busy=0",
               name, instr_ready, cyc, busy, exp_c);
    end
  endtask

  task automatic ack_at(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
  endtask

  task automatic check_rst(input string name);
    logic [31:0] got;
    got = {instr_ready, busy, opl_en, rf_we, flag_we, mem_req, mem_we, err,
           op_sel, ra_addr, rb_addr, rf_waddr, wb_sel};
    checks++;
    if (got != 32'h8000_0000) begin
      errors++;
      $display("FAIL %s: got outputs=%h, expected 80000000", name, got);
    end
  endtask

  task automatic check_bit(input logic got, input logic exp_v, input string name);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0b, expected %0b", name, got, exp_v);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n       = 1'b0;
    instr       = 8'h00;
    instr_valid = 1'b0;
    mem_ack     = 1'b0;
    repeat (2) @(negedge clk);
    check_rst("reset_state");
    rst_n = 1'b1;

    // ADD r1,r2
    issue(8'h06, h);
    expd(h + 1, 2'd1, 2'd2);
    expf(h + 2, 16'h0001);
    expw(h + 3, 2'd1, 2'd0, 16'h0001);
    wait_ready(h + 4, "add_ready");

    // CMP r2,r3: flags only, no RF write
    issue(8'h4B, h);
    expd(h + 1, 2'd2, 2'd3);
    expf(h + 2, 16'h0010);
    wait_ready(h + 3, "cmp_ready");

    // SWP r0,r3
    issue(8'hE3, h);
    expd(h + 1, 2'd0, 2'd3);
    expw(h + 3, 2'd0, 2'd2, 16'h4000);
    expw(h + 4, 2'd3, 2'd1, 16'h4000);
    wait_ready(h + 5, "swp_ready");

    // LOAD r2,r1 with ack in the 4th request cycle
    issue(8'hF9, h);
    expd(h + 1, 2'd2, 2'd1);
    expm(h + 3, 4, 1'b0, 16'h8000);
    expw(h + 7, 2'd2, 2'd3, 16'h8000);
    ack_at(h + 6);
    wait_ready(h + 8, "load_ready");

    // STO r2,r1 with ack in the 2nd request cycle
    issue(8'hD9, h);
    expd(h + 1, 2'd2, 2'd1);
    expm(h + 3, 2, 1'b1, 16'h2000);
    ack_at(h + 4);
    wait_ready(h + 5, "sto_ready");
    check_bit(err, 1'b0, "err_before_timeout");

    // LOAD with no ack: times out after 15 request cycles
    issue(8'hF9, h);
    expd(h + 1, 2'd2, 2'd1);
    expm(h + 3, 15, 1'b0, 16'h8000);
    wait_ready(h + 18, "timeout_ready");
    check_bit(err, 1'b1, "err_after_timeout");

    // ADD r3,r0 still works with err set
    issue(8'h0C, h);
    expd(h + 1, 2'd3, 2'd0);
    expf(h + 2, 16'h0001);
    expw(h + 3, 2'd3, 2'd0, 16'h0001);
    wait_ready(h + 4, "add_after_err");
    check_bit(err, 1'b1, "err_sticky");

    // XOR r2,r3: RF write without flag update
    issue(8'h7B, h);
    expd(h + 1, 2'd2, 2'd3);
    expw(h + 3, 2'd2, 2'd0, 16'h0080);
    wait_ready(h + 4, "xor_ready");

    // NEG r1: flags and write
    issue(8'hC5, h);
    expd(h + 1, 2'd1, 2'd1);
    expf(h + 2, 16'h1000);
    expw(h + 3, 2'd1, 2'd0, 16'h1000);
    wait_ready(h + 4, "neg_ready");

    // SWP r1,r1: both writebacks still occur
    issue(8'hE5, h);
    expd(h + 1, 2'd1, 2'd1);
    expw(h + 3, 2'd1, 2'd2, 16'h4000);
    expw(h + 4, 2'd1, 2'd1, 16'h4000);
    wait_ready(h + 5, "swp_same_ready");

    // mem_ack while idle has no effect
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    check_bit(busy | mem_req | rf_we, 1'b0, "stray_ack_idle");

    // reset in the middle of a LOAD wait
    issue(8'hF9, h);
    expd(h + 1, 2'd2, 2'd1);
    expm(h + 3, 2, 1'b0, 16'h8000);
    while (cyc < h + 5) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_rst("reset_mid_mem");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_bit(instr_ready & ~busy, 1'b1, "idle_after_mem_reset");

    // reset during the second swap writeback
    issue(8'hE3, h);
    expd(h + 1, 2'd0, 2'd3);
    expw(h + 3, 2'd0, 2'd2, 16'h4000);
    while (cyc < h + 4) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check_rst("reset_mid_wb2");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // normal operation after reset
    issue(8'h06, h);
    expd(h + 1, 2'd1, 2'd2);
    expf(h + 2, 16'h0001);
    expw(h + 3, 2'd1, 2'd0, 16'h0001);
    wait_ready(h + 4, "add_after_reset");
    repeat (3) @(negedge clk);

    checks++;
    if (wq.size() != 0 || fq.size() != 0 || mq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got wr=%0d flag=%0d mem=%0d dec=%0d outstanding, expected 0",
               wq.size(), fq.size(), mq.size(), dq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
